// File: rtl/antic_dlist_dma_if.sv
// Memory-fetch and decoded-instruction bus between the display-list DMA and its
// neighbours (memory on one side, the line generator on the other).
interface antic_dlist_dma_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              halt_L;
  logic [7:0]        DB;

  // Handshake: an entry transfers on a rising edge where instr_valid and
  // instr_ready are both 1. While instr_valid is 1 and no transfer happens,
  // instr/lms/lms_addr hold steady; instr_valid never drops without a transfer,
  // except when start flushes the queue.
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr;
  logic              lms;
  logic [ADDR_W-1:0] lms_addr;

  modport master (
    output address, halt_L, instr_valid, instr, lms, lms_addr,
    input  DB, instr_ready
  );

  modport slave (
    input  address, halt_L, instr_valid, instr, lms, lms_addr,
    output DB, instr_ready
  );
endinterface

// File: rtl/antic_dlist_dma.sv
// Display-list DMA fetcher: steals bus cycles to read display-list bytes,
// decodes mode/LMS/JMP/JVB instructions and queues entries for the line generator.
module antic_dlist_dma #(
  parameter int ADDR_W     = 16,
  parameter int WRAP_BITS  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              phi2,
  input  logic              RST_L,
  input  logic              start,
  input  logic [ADDR_W-1:0] dlist_base,
  input  logic              dl_en,
  input  logic              vblank,
  output logic [ADDR_W-1:0] dlistptr,
  output logic [2:0]        cstate,
  antic_dlist_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP   = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    PUSH = 3'd4,
    WVB  = 3'd5
  } state_e;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 8 + 1 + ADDR_W;
  // Only the low WRAP_BITS of the pointer count; upper bits pick the window.
  localparam logic [ADDR_W-1:0] WRAP_MASK = ~({ADDR_W{1'b1}} << WRAP_BITS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] target;

  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    cnt_q;
  logic              push, pop, flush, full, empty;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  head;

  assign ptr_inc = (ptr_q & ~WRAP_MASK) | ((ptr_q + ADDR_W'(1)) & WRAP_MASK);
  assign target  = ADDR_W'({bus.DB, lo_q});

  assign full  = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && bus.instr_ready;

  always_ff @(posedge phi2) begin
    if (!RST_L) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      op_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    lo_d      = lo_q;
    push      = 1'b0;
    push_data = '0;
    flush     = 1'b0;
    if (start) begin
      ptr_d   = dlist_base;
      flush   = 1'b1;
      state_d = dl_en ? OP : IDLE;
    end else begin
      case (state_q)
        IDLE: if (dl_en) state_d = OP;
        OP: begin
          if (!dl_en) begin
            state_d = IDLE;
          end else if (!full) begin
            op_d  = bus.DB;
            ptr_d = ptr_inc;
            // JMP/JVB (m=1) and LMS modes carry a two-byte operand.
            if ((bus.DB[3:0] == 4'd1) || ((bus.DB[3:0] != 4'd0) && bus.DB[6]))
              state_d = LO;
            else
              state_d = PUSH;
          end
        end
        LO: begin
          lo_d    = bus.DB;
          ptr_d   = ptr_inc;
          state_d = HI;
        end
        HI: begin
          if (op_q[3:0] == 4'd1) begin
            ptr_d = target;
            if (op_q[6]) begin
              push      = 1'b1;
              push_data = {op_q, 1'b0, {ADDR_W{1'b0}}};
              state_d   = WVB;
            end else begin
              state_d = OP;
            end
          end else begin
            ptr_d     = ptr_inc;
            push      = 1'b1;
            push_data = {op_q, 1'b1, target};
            state_d   = OP;
          end
          if (!dl_en) state_d = IDLE;
        end
        PUSH: begin
          push      = 1'b1;
          push_data = {op_q, 1'b0, {ADDR_W{1'b0}}};
          state_d   = dl_en ? OP : IDLE;
        end
        WVB: begin
          if (!dl_en)      state_d = IDLE;
          else if (vblank) state_d = OP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge phi2) begin
    if (!RST_L) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: head outputs are masked while the queue is empty.
  always_ff @(posedge phi2) begin
    if (RST_L && !flush && push) fifo_q[wr_q] <= push_data;
  end

  assign head            = fifo_q[rd_q];
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? 8'h00 : head[ENT_W-1 -: 8];
  assign bus.lms         = !empty && head[ADDR_W];
  assign bus.lms_addr    = empty ? '0 : head[ADDR_W-1:0];

  assign bus.address = ptr_q;
  assign bus.halt_L  = !(((state_q == OP) && !full) || (state_q == LO) || (state_q == HI));
  assign dlistptr    = ptr_q;
  assign cstate      = state_q;

endmodule

// File: tb/tb_antic_dlist_dma.sv
// Directed bench for antic_dlist_dma: plain list, JMP/JVB, back-pressure,
// pointer wrap, start abort and reset mid-LMS.
module tb_antic_dlist_dma;

  logic        phi2;
  logic        RST_L;
  logic        start;
  logic [15:0] dlist_base;
  logic        dl_en;
  logic        vblank;
  logic [15:0] dlistptr;
  logic [2:0]  cstate;

  logic [7:0]  mem [0:65535];
  logic [24:0] exp_q [$];
  logic [24:0] pop_q [$];
  int          checks;
  int          errors;
  int          halt_cnt;

  antic_dlist_dma_if #(.ADDR_W(16)) bus ();

  antic_dlist_dma #(.ADDR_W(16), .WRAP_BITS(10), .FIFO_DEPTH(4)) dut (
    .phi2       (phi2),
    .RST_L      (RST_L),
    .start      (start),
    .dlist_base (dlist_base),
    .dl_en      (dl_en),
    .vblank     (vblank),
    .dlistptr   (dlistptr),
    .cstate     (cstate),
    .bus        (bus.master)
  );

  // clock / memory model / monitors
  initial begin
    phi2 = 1'b0;
    forever #5 phi2 = ~phi2;
  end

  assign bus.DB = bus.halt_L ? 8'h00 : mem[bus.address];

  always @(posedge phi2) begin
    if (!bus.halt_L) halt_cnt <= halt_cnt + 1;
    if (RST_L && bus.instr_valid && bus.instr_ready)
      pop_q.push_back({bus.instr, bus.lms, bus.lms_addr});
  end

  // driver tasks
  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_pops(input string tag);
    chk({tag, "_count"}, pop_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < pop_q.size()) chk({tag, "_entry"}, {7'd0, pop_q[i]}, {7'd0, exp_q[i]});
    end
    pop_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    halt_cnt        = 0;
    RST_L           = 1'b0;
    start           = 1'b0;
    dl_en           = 1'b0;
    vblank          = 1'b0;
    dlist_base      = 16'h0000;
    bus.instr_ready = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    repeat (2) step();
    RST_L = 1'b1;

    chk("rst_cstate",   cstate, 3'd0);
    chk("rst_halt",     bus.halt_L, 1'b1);
    chk("rst_valid",    bus.instr_valid, 1'b0);
    chk("rst_instr",    bus.instr, 8'h00);
    chk("rst_lms",      bus.lms, 1'b0);
    chk("rst_lms_addr", bus.lms_addr, 16'h0000);
    chk("rst_ptr",      dlistptr, 16'h0000);
    chk("rst_addr",     bus.address, 16'h0000);

    // plain list: 70 70 42 00 40 02
    mem[16'h2000] = 8'h70; mem[16'h2001] = 8'h70; mem[16'h2002] = 8'h42;
    mem[16'h2003] = 8'h00; mem[16'h2004] = 8'h40; mem[16'h2005] = 8'h02;
    exp_q.push_back({8'h70, 1'b0, 16'h0000});
    exp_q.push_back({8'h70, 1'b0, 16'h0000});
    exp_q.push_back({8'h42, 1'b1, 16'h4000});
    exp_q.push_back({8'h02, 1'b0, 16'h0000});
    bus.instr_ready = 1'b1;
    dlist_base = 16'h2000; start = 1'b1; dl_en = 1'b1; halt_cnt = 0;
    step();
    start = 1'b0;
    chk("plain_first_addr",  bus.address, 16'h2000);
    chk("plain_first_state", cstate, 3'd1);
    chk("plain_first_halt",  bus.halt_L, 1'b0);
    repeat (8) step();
    chk("plain_push_state", cstate, 3'd4);
    dl_en = 1'b0;
    repeat (3) step();
    chk("plain_halt_cnt", halt_cnt, 6);
    chk("plain_ptr",      dlistptr, 16'h2006);
    chk("plain_idle",     cstate, 3'd0);
    check_pops("plain_pop");

    // JMP to 2010, then JVB back to 2000 and wait for vblank
    mem[16'h2000] = 8'h01; mem[16'h2001] = 8'h10; mem[16'h2002] = 8'h20;
    mem[16'h2010] = 8'h41; mem[16'h2011] = 8'h00; mem[16'h2012] = 8'h20;
    exp_q.push_back({8'h41, 1'b0, 16'h0000});
    dlist_base = 16'h2000; start = 1'b1; dl_en = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("jmp_ptr",   dlistptr, 16'h2010);
    chk("jmp_addr",  bus.address, 16'h2010);
    chk("jmp_state", cstate, 3'd1);
    repeat (3) step();
    chk("jvb_state", cstate, 3'd5);
    chk("jvb_ptr",   dlistptr, 16'h2000);
    halt_cnt = 0;
    repeat (50) step();
    chk("wvb_halt_cnt", halt_cnt, 0);
    chk("wvb_state",    cstate, 3'd5);
    chk("wvb_halt",     bus.halt_L, 1'b1);
    vblank = 1'b1;
    step();
    vblank = 1'b0;
    chk("vbl_state", cstate, 3'd1);
    chk("vbl_addr",  bus.address, 16'h2000);
    chk("vbl_halt",  bus.halt_L, 1'b0);
    dl_en = 1'b0;
    step();
    chk("jvb_idle", cstate, 3'd0);
    check_pops("jvb_pop");

    // back-pressure: eight 02 entries, nobody popping
    for (int a = 0; a < 8; a++) mem[16'h2100 + a] = 8'h02;
    bus.instr_ready = 1'b0;
    dlist_base = 16'h2100; start = 1'b1; dl_en = 1'b1; halt_cnt = 0;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("bp_halt_cnt", halt_cnt, 4);
    chk("bp_state",    cstate, 3'd1);
    chk("bp_halt",     bus.halt_L, 1'b1);
    chk("bp_ptr",      dlistptr, 16'h2104);
    chk("bp_valid",    bus.instr_valid, 1'b1);
    chk("bp_instr",    bus.instr, 8'h02);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("bp_resume_halt", bus.halt_L, 1'b0);
    chk("bp_resume_addr", bus.address, 16'h2104);
    repeat (5) step();
    chk("bp_halt_cnt2", halt_cnt, 5);
    chk("bp_ptr2",      dlistptr, 16'h2105);
    chk("bp_stall2",    bus.halt_L, 1'b1);
    chk("bp_pops",      pop_q.size(), 1);
    pop_q.delete();
    start = 1'b1; dl_en = 1'b0;
    step();
    start = 1'b0;
    chk("bp_flush_valid", bus.instr_valid, 1'b0);
    chk("bp_flush_state", cstate, 3'd0);

    // wrap inside the 1 KB window
    mem[16'h23FF] = 8'h02;
    exp_q.push_back({8'h02, 1'b0, 16'h0000});
    bus.instr_ready = 1'b1;
    dlist_base = 16'h23FF; start = 1'b1; dl_en = 1'b1;
    step();
    start = 1'b0;
    chk("wrap_addr1", bus.address, 16'h23FF);
    repeat (2) step();
    chk("wrap_addr2", bus.address, 16'h2000);
    chk("wrap_halt",  bus.halt_L, 1'b0);
    dl_en = 1'b0;
    step();
    chk("wrap_idle", cstate, 3'd0);
    chk("wrap_ptr",  dlistptr, 16'h2000);
    repeat (2) step();
    check_pops("wrap_pop");

    // abort during HI of an LMS
    mem[16'h2200] = 8'h42; mem[16'h2201] = 8'h00; mem[16'h2202] = 8'h50;
    mem[16'h3000] = 8'h02;
    bus.instr_ready = 1'b0;
    dlist_base = 16'h2200; start = 1'b1; dl_en = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    chk("abort_hi_state", cstate, 3'd3);
    dlist_base = 16'h3000; start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_valid", bus.instr_valid, 1'b0);
    chk("abort_addr",  bus.address, 16'h3000);
    chk("abort_state", cstate, 3'd1);
    chk("abort_halt",  bus.halt_L, 1'b0);
    repeat (2) step();
    chk("abort_head_valid", bus.instr_valid, 1'b1);
    chk("abort_head_instr", bus.instr, 8'h02);
    chk("abort_head_lms",   bus.lms, 1'b0);
    chk("abort_head_laddr", bus.lms_addr, 16'h0000);
    bus.instr_ready = 1'b1; dl_en = 1'b0;
    step();
    bus.instr_ready = 1'b0;
    chk("abort_drained", bus.instr_valid, 1'b0);
    pop_q.delete();

    // reset held two cycles in the middle of an LMS, with start asserted
    dlist_base = 16'h2200; start = 1'b1; dl_en = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_lms_state", cstate, 3'd2);
    RST_L = 1'b0; start = 1'b1;
    repeat (2) step();
    chk("rst2_cstate", cstate, 3'd0);
    chk("rst2_halt",   bus.halt_L, 1'b1);
    chk("rst2_valid",  bus.instr_valid, 1'b0);
    chk("rst2_ptr",    dlistptr, 16'h0000);
    chk("rst2_addr",   bus.address, 16'h0000);
    RST_L = 1'b1; start = 1'b0; dl_en = 1'b0;
    step();
    chk("rst2_idle", cstate, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/antic_dlist_dma.md
# antic_dlist_dma

Parametrised display-list DMA fetcher for the ANTIC path. It steals bus cycles from the CPU via `halt_L` to read display-list bytes. It decodes mode, LMS, JMP and JVB instructions and queues decoded entries in a small FIFO for the line generator. It succeeds the hard-wired display-list pointer logic with configurable address width, pointer wrap window and queue depth, and adds back-pressure, jump and vertical-blank resume handling.

## Interface
- `ADDR_W`, 16, address bus and pointer width.
- `WRAP_BITS`, 10, low pointer bits that increment; bits above are held (1 KB display-list window).
- `FIFO_DEPTH`, 4, decoded-instruction queue entries (power of 2, ≥2).

- `phi2` in 1: system clock; all state changes on rising edge.
- `RST_L` in 1: synchronous active-low reset, sampled on `phi2` rising edge.
- `start` in 1: one-cycle pulse; load pointer from `dlist_base`, flush FIFO, begin fetching.
- `dlist_base` in `ADDR_W`: display-list start address (DLISTH:DLISTL).
- `dl_en` in 1: display-list DMA enable (DMACTL bit 5).
- `vblank` in 1: one-cycle pulse at start of vertical blank.
- `DB` in 8: memory data, valid in the same cycle `address` is driven with `halt_L`=0.
- `address` out `ADDR_W`: fetch address; holds the pointer when idle.
- `halt_L` out 1: low in every cycle a byte is read.
- `instr_valid` out 1, `instr_ready` in 1: FIFO output handshake; an entry transfers when both are 1.
- `instr` out 8: raw instruction byte of the head entry.
- `lms` out 1, `lms_addr` out `ADDR_W`: head entry carries a load-memory-scan address.
- `dlistptr` out `ADDR_W`: current pointer.
- `cstate` out 3: state encoding, for debug.

## Operation
- States and `cstate` encodings: IDLE=0, OP=1, LO=2, HI=3, PUSH=4, WVB=5.
- IDLE:
  - `start` loads the pointer and goes to OP if `dl_en`=1.
  - Without `start`, `dl_en`=1 alone moves to OP from the current pointer.
- OP:
  - If the FIFO is full, stall with `halt_L`=1 and no read.
  - Otherwise read the byte at the pointer, latch it as the opcode, and increment the pointer.
- Decode on the latched opcode, where m=op[3:0]:
  - m=1 (JMP/JVB): go to LO.
  - m≥2 with op[6]=1 (LMS): go to LO.
  - All other opcodes (m=0 blank, or m≥2 without LMS): go to PUSH.
- LO/HI:
  - Each state reads one byte and increments the pointer.
  - LO then HI build a 16-bit target, low byte first, zero-extended or truncated to `ADDR_W`.
  - JMP (op[6]=0): pointer := target; go to OP; nothing is pushed.
  - JVB (op[6]=1): pointer := target; push opcode; go to WVB.
  - LMS: push {op, lms=1, target}; go to OP.
- PUSH: write {op, lms=0, 0} into the FIFO; go to OP. PUSH never reads memory.
- WVB: stay, with `halt_L`=1, until `vblank`, then go to OP.
- Pointer increment: only bits [WRAP_BITS-1:0] count. 0x03FF+1 becomes 0x0000 with the upper bits unchanged. Jumps load all bits.
- `dl_en` falling:
  - In OP or WVB: go to IDLE at the next edge.
  - In LO/HI: finish the current instruction first (including its push), then go to IDLE.
- `start` in a non-IDLE state: reload the pointer, flush the FIFO, and go to OP (or IDLE if `dl_en`=0). This takes priority over every other transition in that cycle.
- FIFO:
  - Push and pop in the same cycle are both allowed, including when full (a pop frees a slot in the same cycle).
  - `instr_valid` = not empty.
  - Head outputs are stable until popped.

## Timing
- Reset (`RST_L`=0 at an edge) gives:
  - state IDLE, pointer 0, FIFO empty
  - `address`=0, `halt_L`=1, `instr_valid`=0, `instr`=0, `lms`=0, `lms_addr`=0, `dlistptr`=0, `cstate`=0
- Reset overrides `start`, including mid-fetch and mid-LMS.
- `halt_L` is a registered-state decode: low exactly in OP (not stalled), LO and HI. It has no glitch cycles.
- Cycles per instruction from OP to the next OP, with no stall:
  - plain: 2 (1 read)
  - LMS: 3 (3 reads)
  - JMP: 3 (3 reads)
- Latency: an entry is visible on `instr_valid` 1 cycle after the PUSH state (or after HI for LMS/JVB).
- The `start` pulse to the first read is 1 cycle: `address`=`dlist_base` in the cycle after `start`.

## Test plan
- Reset: hold `RST_L`=0 two cycles mid-LMS -> `cstate`=0, `halt_L`=1, `instr_valid`=0, `dlistptr`=0000.
- Plain list: base 0x2000 holding 70 70 42 00 40 02, `instr_ready`=1 -> pop sequence 70, 70, 42(lms=1, `lms_addr`=4000), 02. `halt_L` low in 6 cycles total; `dlistptr`=2006.
- JMP/JVB: at 0x2000, 01 10 20, with 0x2010 holding 41 00 20 -> pointer 2010. Then pop 41, WVB holds with `halt_L`=1 for 50 cycles. `vblank` pulse -> next read at 0x2000.
- Back-pressure: `instr_ready`=0, FIFO_DEPTH=4, list of eight 02 -> exactly 4 reads, then `halt_L`=1 in OP. Raising `instr_ready` for 1 cycle yields 1 pop, then 1 new read.
- Wrap: base 0x23FF holding 02, next byte at 0x2000 -> second read `address`=2000, not 2400.
- Abort: `start` with base 0x3000 during HI of an LMS -> FIFO empty next cycle; the partial LMS entry is never pushed; next read at 0x3000.
